// File: rtl/bank_display.sv
// Bank balance to 4-digit multiplexed 7-segment display (common anode).
// An iterative double-dabble converter re-snapshots the balance every 16 cycles.
module bank_display #(
  parameter int unsigned BAL_W       = 27,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BAL_W-1:0] balance,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int unsigned VAL_W      = 14;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned MAX_VAL    = 9999;
  localparam int unsigned SHIFT_LAST = VAL_W - 1;
  localparam int unsigned CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [3:0]         bit_cnt;
  logic [VAL_W-1:0]   val;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf_snap;
  logic [BCD_W-1:0]   digits;
  logic               ovf;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         idx;
  logic               over_range;
  logic [VAL_W-1:0]   clamped;
  logic [3:0]         cur_digit;
  logic               blank;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b0111111;
    endcase
  endfunction

  // Clamp out-of-range balances to 9999 and flag overflow.
  always_comb begin
    over_range = (balance > BAL_W'(MAX_VAL));
    clamped    = over_range ? VAL_W'(MAX_VAL) : balance[VAL_W-1:0];
  end

  // Add-3 correction on every BCD nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> 14 x SHIFT -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == 4'(SHIFT_LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: snapshot, shift-add-3, then publish digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      val      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_snap <= 1'b0;
      digits   <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          val      <= clamped;
          ovf_snap <= over_range;
          bcd      <= '0;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          {bcd, val} <= {bcd_adj[BCD_W-2:0], val, 1'b0};
          bit_cnt    <= bit_cnt + 4'd1;
        end
        DONE: begin
          digits <= bcd;
          ovf    <= ovf_snap;
        end
        default: ;
      endcase
    end
  end

  // Busy tracks whether the following cycle is part of a conversion.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_next != IDLE);
  end

  // Refresh divider and digit index for display multiplexing.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Select the active digit and decide leading-zero blanking.
  always_comb begin
    cur_digit = digits[{idx, 2'b00} +: 4];
    blank     = 1'b0;
    if (BLANK_LZ) begin
      case (idx)
        2'd1:    blank = (digits[15:4] == 12'd0);
        2'd2:    blank = (digits[15:8] == 8'd0);
        2'd3:    blank = (digits[15:12] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
  end

  // Registered display drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h7F;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= blank ? 7'h7F : encode(cur_digit);
      an  <= ~(4'b0001 << idx);
      dp  <= ~((idx == 2'd3) && ovf);
    end
  end

endmodule

// File: tb/tb_bank_display.sv
// Directed bench for bank_display with a fast refresh divider.
module tb_bank_display;

  localparam int unsigned BAL_W = 27;

  logic             clk = 1'b0;
  logic             rst;
  logic [BAL_W-1:0] balance;
  logic [6:0]       seg, seg_nb;
  logic             dp, dp_nb;
  logic [3:0]       an, an_nb;
  logic             busy, busy_nb;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_a [4];
  logic [6:0] seg_b [4];
  logic       dp_a  [4];

  always #5 clk = ~clk;

  bank_display #(.BAL_W(BAL_W), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .balance(balance),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  bank_display #(.BAL_W(BAL_W), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .balance(balance),
    .seg(seg_nb), .dp(dp_nb), .an(an_nb), .busy(busy_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture one full scan starting at the ones slot.
  task automatic scan();
    int n;
    int dwell;
    logic [3:0] pat;
    n = 0;
    while (an !== 4'b0111 && n < 50) begin @(negedge clk); n++; end
    while (an !== 4'b1110 && n < 50) begin @(negedge clk); n++; end
    check("scan_sync", 32'(n < 50), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pat = ~(4'b0001 << i);
      check("an_slot", 32'(an), 32'(pat));
      seg_a[i] = seg;
      seg_b[i] = seg_nb;
      dp_a[i]  = dp;
      dwell = 0;
      while (an === pat && dwell < 20) begin @(negedge clk); dwell++; end
      check("dwell", 32'(dwell), 32'd4);
    end
  endtask

  task automatic expect_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] dpe);
    scan();
    check({tag, "_seg0"}, 32'(seg_a[0]), 32'(e0));
    check({tag, "_seg1"}, 32'(seg_a[1]), 32'(e1));
    check({tag, "_seg2"}, 32'(seg_a[2]), 32'(e2));
    check({tag, "_seg3"}, 32'(seg_a[3]), 32'(e3));
    check({tag, "_dp"}, 32'({dp_a[3], dp_a[2], dp_a[1], dp_a[0]}), 32'(dpe));
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_hi;
    int first_cyc;
    int n;
    bit ended;

    rst = 1'b1;
    balance = '0;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // balance=100: busy pulse length and first-result latency
    balance = BAL_W'(100);
    rst = 1'b0;
    busy_hi = 0; first_cyc = -1; ended = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy && !ended) busy_hi++;
      if (!busy && busy_hi > 0) ended = 1'b1;
      if (first_cyc < 0 && dut.digits == 16'h0100) first_cyc = c;
    end
    check("busy_len", 32'(busy_hi), 32'd15);
    check("latency_100", 32'(first_cyc), 32'd16);
    expect_display("b100", 7'h40, 7'h40, 7'h79, 7'h7F, 4'hF);

    balance = BAL_W'(1000);
    repeat (40) @(negedge clk);
    expect_display("b1000", 7'h40, 7'h40, 7'h40, 7'h79, 4'hF);

    balance = BAL_W'(0);
    repeat (40) @(negedge clk);
    expect_display("b0", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);

    balance = BAL_W'(12345);
    repeat (40) @(negedge clk);
    expect_display("b12345", 7'h10, 7'h10, 7'h10, 7'h10, 4'b0111);

    balance = BAL_W'(7);
    repeat (40) @(negedge clk);
    expect_display("b7", 7'h78, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    check("nolz_seg0", 32'(seg_b[0]), 32'h78);
    check("nolz_seg1", 32'(seg_b[1]), 32'h40);
    check("nolz_seg2", 32'(seg_b[2]), 32'h40);
    check("nolz_seg3", 32'(seg_b[3]), 32'h40);

    // change 100 -> 57 on the 3rd SHIFT cycle
    balance = BAL_W'(100);
    repeat (40) @(negedge clk);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    while (!busy && n < 40) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    balance = BAL_W'(57);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    check("midconv_keep", 32'(dut.digits), 32'h0100);
    first_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > n) begin
        @(negedge clk);
        if (first_cyc < 0 && dut.digits == 16'h0057) first_cyc = c;
      end
    end
    check("midconv_new", 32'(first_cyc), 32'd29);

    // reset during SHIFT
    balance = BAL_W'(1234);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    while (!busy && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dp", 32'(dp), 32'd1);
    check("midrst_digits", 32'(dut.digits), 32'd0);
    rst = 1'b0;
    first_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (first_cyc < 0 && dut.digits == 16'h1234) first_cyc = c;
    end
    check("postrst_lat", 32'(first_cyc), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
